// File: rtl/wb_ddr_port_arbiter_pkg.sv
// Shared constants and state type for the Wishbone DDR port arbiter.
package wb_ddr_port_arbiter_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_ddr_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr, searching upward with wrap.
module wb_ddr_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int GW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [GW-1:0]        i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [GW-1:0]        o_idx,
  output logic                 o_valid
);

  int            w_candInt;
  logic [GW-1:0] w_cand;

  // Wrap by subtracting NUM_PORTS so non-power-of-two port counts rotate correctly
  always_comb begin
    o_gnt     = '0;
    o_idx     = '0;
    o_valid   = 1'b0;
    w_candInt = 0;
    w_cand    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_candInt = int'(i_ptr) + i;
      if (w_candInt >= NUM_PORTS) w_candInt = w_candInt - NUM_PORTS;
      w_cand = GW'(w_candInt);
      if (!o_valid && i_req[w_cand]) begin
        o_valid       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_ddr_port_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between NUM_PORTS masters.
// Define WB_DDR_ARB_STATS_EN to build the per-port wait-cycle counters.
module wb_ddr_port_arbiter
  import wb_ddr_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic [NUM_PORTS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_PORTS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_PORTS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_PORTS-1:0]      wbm_we_i,
  input  logic [NUM_PORTS-1:0]      wbm_cyc_i,
  input  logic [NUM_PORTS-1:0]      wbm_stb_i,
  input  logic [NUM_PORTS*3-1:0]    wbm_cti_i,
  input  logic [NUM_PORTS*2-1:0]    wbm_bte_i,
  output logic [NUM_PORTS*DW-1:0]   wbm_dat_o,
  output logic [NUM_PORTS-1:0]      wbm_ack_o,
  output logic [NUM_PORTS-1:0]      wbm_err_o,
  output logic [AW-1:0]             wbs_adr_o,
  output logic [DW-1:0]             wbs_dat_o,
  output logic [DW/8-1:0]           wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [DW-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  output logic [NUM_PORTS*32-1:0]   stat_wait_o
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int SW = DW / 8;

  arb_state_e           r_state, w_stateNext;
  logic [GW-1:0]        r_grant, w_grantNext;
  logic [GW-1:0]        r_rrPtr, w_rrPtrNext;
  logic [NUM_PORTS-1:0] r_grantOh, w_grantOhNext;
  logic [NUM_PORTS-1:0] w_pickGnt;
  logic [GW-1:0]        w_pickIdx;
  logic                 w_pickValid;
  logic [2:0]           w_grantCti;
  logic                 w_release;

  wb_ddr_rr_pick #(.NUM_PORTS(NUM_PORTS), .GW(GW)) u_pick (
    .i_req   (wbm_cyc_i),
    .i_ptr   (r_rrPtr),
    .o_gnt   (w_pickGnt),
    .o_idx   (w_pickIdx),
    .o_valid (w_pickValid)
  );

  // An EOB beat frees the bus even when the master keeps cyc high
  assign w_grantCti = wbm_cti_i[r_grant*3 +: 3];
  assign w_release  = (r_state == ARB_GRANT) &&
                      (!wbm_cyc_i[r_grant] ||
                       ((wbs_ack_i || wbs_err_i) && (w_grantCti == CTI_EOB)));

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      r_state   <= ARB_IDLE;
      r_grant   <= '0;
      r_grantOh <= '0;
      r_rrPtr   <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_grant   <= w_grantNext;
      r_grantOh <= w_grantOhNext;
      r_rrPtr   <= w_rrPtrNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_grantNext   = r_grant;
    w_grantOhNext = r_grantOh;
    w_rrPtrNext   = r_rrPtr;
    case (r_state)
      ARB_IDLE: begin
        if (w_pickValid) begin
          w_stateNext   = ARB_GRANT;
          w_grantNext   = w_pickIdx;
          w_grantOhNext = w_pickGnt;
        end
      end
      ARB_GRANT: begin
        if (w_release) begin
          w_stateNext   = ARB_IDLE;
          w_grantOhNext = '0;
          w_rrPtrNext   = (r_grant == GW'(NUM_PORTS - 1)) ? '0 : r_grant + GW'(1);
        end
      end
      default: w_stateNext = ARB_IDLE;
    endcase
  end

  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_dat_o = '0;
    if (r_state == ARB_GRANT) begin
      wbs_adr_o = wbm_adr_i[r_grant*AW +: AW];
      wbs_dat_o = wbm_dat_i[r_grant*DW +: DW];
      wbs_sel_o = wbm_sel_i[r_grant*SW +: SW];
      wbs_we_o  = wbm_we_i[r_grant];
      wbs_cyc_o = wbm_cyc_i[r_grant];
      wbs_stb_o = wbm_stb_i[r_grant];
      wbs_cti_o = w_grantCti;
      wbs_bte_o = wbm_bte_i[r_grant*2 +: 2];
      wbm_ack_o = r_grantOh & {NUM_PORTS{wbs_ack_i}};
      wbm_err_o = r_grantOh & {NUM_PORTS{wbs_err_i}};
      wbm_dat_o = {NUM_PORTS{wbs_dat_i}};
    end
  end

`ifdef WB_DDR_ARB_STATS_EN
  logic [31:0] r_statWait [NUM_PORTS];

  // A port waits whenever it holds cyc but is not the one owning the bus
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      for (int p = 0; p < NUM_PORTS; p++) r_statWait[p] <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (wbm_cyc_i[p] && !((r_state == ARB_GRANT) && r_grantOh[p]) &&
            (r_statWait[p] != 32'hFFFF_FFFF))
          r_statWait[p] <= r_statWait[p] + 32'd1;
      end
    end
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_stat
    assign stat_wait_o[gp*32 +: 32] = r_statWait[gp];
  end
`else
  assign stat_wait_o = '0;
`endif

endmodule

// File: tb/tb_wb_ddr_port_arbiter.sv
// Self-checking bench for wb_ddr_port_arbiter: directed scenarios plus random traffic against an owner/pointer model.
module tb_wb_ddr_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  logic            wb_clk = 1'b0;
  logic            wb_rst;
  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*SW-1:0] wbm_sel_i;
  logic [N-1:0]    wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [N*3-1:0]  wbm_cti_i;
  logic [N*2-1:0]  wbm_bte_i;
  logic [N*DW-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [SW-1:0]   wbs_sel_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;
  logic [DW-1:0]   wbs_dat_i;
  logic            wbs_ack_i, wbs_err_i;
  logic [N*32-1:0] stat_wait_o;

  int compared   = 0;
  int mismatched = 0;

  // Model: which port owns the bus (-1 = nobody), where the rotation resumes, wait counts
  int          mOwner = -1;
  int          mPtr   = 0;
  logic [31:0] mStat [N];

  always #5 wb_clk = ~wb_clk;

  wb_ddr_port_arbiter #(.NUM_PORTS(N), .AW(AW), .DW(DW)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .stat_wait_o(stat_wait_o)
  );

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelCheck();
    logic [AW-1:0]   eAdr = '0;
    logic [DW-1:0]   eDat = '0;
    logic [SW-1:0]   eSel = '0;
    logic            eWe = 1'b0, eCyc = 1'b0, eStb = 1'b0;
    logic [2:0]      eCti = '0;
    logic [1:0]      eBte = '0;
    logic [N-1:0]    eAck = '0, eErr = '0;
    logic [N*DW-1:0] eDatO = '0;
    logic [N*32-1:0] eStat = '0;
    if (mOwner >= 0) begin
      eAdr = wbm_adr_i[mOwner*AW +: AW];
      eDat = wbm_dat_i[mOwner*DW +: DW];
      eSel = wbm_sel_i[mOwner*SW +: SW];
      eWe  = wbm_we_i[mOwner];
      eCyc = wbm_cyc_i[mOwner];
      eStb = wbm_stb_i[mOwner];
      eCti = wbm_cti_i[mOwner*3 +: 3];
      eBte = wbm_bte_i[mOwner*2 +: 2];
      eAck[mOwner] = wbs_ack_i;
      eErr[mOwner] = wbs_err_i;
      for (int p = 0; p < N; p++) eDatO[p*DW +: DW] = wbs_dat_i;
    end
`ifdef WB_DDR_ARB_STATS_EN
    for (int p = 0; p < N; p++) eStat[p*32 +: 32] = mStat[p];
`endif
    checkOutput("wbs_adr", wbs_adr_o, eAdr);
    checkOutput("wbs_dat", wbs_dat_o, eDat);
    checkOutput("wbs_sel", wbs_sel_o, eSel);
    checkOutput("wbs_we", wbs_we_o, eWe);
    checkOutput("wbs_cyc", wbs_cyc_o, eCyc);
    checkOutput("wbs_stb", wbs_stb_o, eStb);
    checkOutput("wbs_cti", wbs_cti_o, eCti);
    checkOutput("wbs_bte", wbs_bte_o, eBte);
    checkOutput("wbm_ack", wbm_ack_o, eAck);
    checkOutput("wbm_err", wbm_err_o, eErr);
    checkOutput("wbm_dat", wbm_dat_o, eDatO);
    checkOutput("stat_wait", stat_wait_o, eStat);
  endtask

  task automatic modelAdvance();
    if (wb_rst) begin
      mOwner = -1;
      mPtr   = 0;
      for (int p = 0; p < N; p++) mStat[p] = '0;
    end else begin
      for (int p = 0; p < N; p++)
        if (wbm_cyc_i[p] && mOwner != p && mStat[p] != 32'hFFFF_FFFF) mStat[p]++;
      if (mOwner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (mOwner < 0 && wbm_cyc_i[(mPtr + k) % N]) mOwner = (mPtr + k) % N;
        end
      end else if (!wbm_cyc_i[mOwner] ||
                   ((wbs_ack_i || wbs_err_i) && wbm_cti_i[mOwner*3 +: 3] == CTI_EOB)) begin
        mPtr   = (mOwner + 1) % N;
        mOwner = -1;
      end
    end
  endtask

  // Called at the negative edge; returns just after the following rising edge
  task automatic stepCycle();
    modelCheck();
    modelAdvance();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic clearInputs();
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0; wbm_we_i = '0;
    wbm_cyc_i = '0; wbm_stb_i = '0; wbm_cti_i = '0; wbm_bte_i = '0;
    wbs_dat_i = '0; wbs_ack_i = 1'b0; wbs_err_i = 1'b0;
  endtask

  task automatic doReset();
    wb_rst = 1'b1;
    clearInputs();
    @(negedge wb_clk);
    stepCycle();
    wb_rst = 1'b0;
  endtask

  task automatic setPort(input int p, input logic cyc, input logic [31:0] adr,
                         input logic we, input logic [2:0] cti);
    wbm_cyc_i[p] = cyc;
    wbm_stb_i[p] = cyc;
    wbm_adr_i[p*AW +: AW] = adr;
    wbm_dat_i[p*DW +: DW] = adr ^ 32'h5A5A_0000;
    wbm_sel_i[p*SW +: SW] = 4'hF;
    wbm_we_i[p] = we;
    wbm_cti_i[p*3 +: 3] = cti;
    wbm_bte_i[p*2 +: 2] = 2'b00;
  endtask

  task automatic waitGrant(input string name);
    int n = 0;
    while (!wbs_cyc_o && n < 8) begin
      stepCycle();
      @(negedge wb_clk);
      n++;
    end
    checkOutput({name, "_granted"}, wbs_cyc_o, 1'b1);
  endtask

  task automatic applyStimulus();
    logic [2:0] ctiPick [3];
    ctiPick[0] = CTI_CLASSIC; ctiPick[1] = CTI_INC; ctiPick[2] = CTI_EOB;
    wb_rst = ($urandom_range(0, 99) == 0);
    for (int p = 0; p < N; p++) begin
      if ($urandom_range(0, 3) == 0) wbm_cyc_i[p] = ~wbm_cyc_i[p];
      wbm_stb_i[p] = wbm_cyc_i[p] & ($urandom_range(0, 4) != 0);
      wbm_adr_i[p*AW +: AW] = $urandom;
      wbm_dat_i[p*DW +: DW] = $urandom;
      wbm_sel_i[p*SW +: SW] = 4'($urandom);
      wbm_we_i[p] = 1'($urandom);
      wbm_cti_i[p*3 +: 3] = ctiPick[$urandom_range(0, 2)];
      wbm_bte_i[p*2 +: 2] = 2'($urandom);
    end
    wbs_ack_i = 1'($urandom);
    wbs_err_i = !wbs_ack_i && ($urandom_range(0, 7) == 0);
    wbs_dat_i = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order [4];
    int g;
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
    wb_rst = 1'b1;
    clearInputs();
    for (int p = 0; p < N; p++) mStat[p] = '0;
    @(posedge wb_clk);
    #1;
    @(negedge wb_clk);
    checkOutput("reset_cyc", wbs_cyc_o, 1'b0);
    checkOutput("reset_ack", wbm_ack_o, 3'b000);
    checkOutput("reset_stat", stat_wait_o, 96'h0);
    stepCycle();
    wb_rst = 1'b0;

    // Single master classic write on port 1
    setPort(1, 1'b1, 32'h100, 1'b1, CTI_CLASSIC);
    @(negedge wb_clk);
    checkOutput("t1_arb_latency", wbs_cyc_o, 1'b0);
    stepCycle();
    wbs_ack_i = 1'b1;
    @(negedge wb_clk);
    checkOutput("t1_cyc_up", wbs_cyc_o, 1'b1);
    checkOutput("t1_adr", wbs_adr_o, 32'h100);
    checkOutput("t1_ack_only_p1", wbm_ack_o, 3'b010);
    stepCycle();
    wbs_ack_i = 1'b0;
    setPort(1, 1'b0, 32'h100, 1'b1, CTI_CLASSIC);
    @(negedge wb_clk);
    checkOutput("t1_drop", wbs_cyc_o, 1'b0);
    stepCycle();
    setPort(1, 1'b1, 32'h200, 1'b0, CTI_CLASSIC);
    setPort(2, 1'b1, 32'h300, 1'b0, CTI_CLASSIC);
    @(negedge wb_clk);
    stepCycle();
    @(negedge wb_clk);
    checkOutput("t1_ptr_is_2", wbs_adr_o, 32'h300);
    stepCycle();
    doReset();

    // All three request together: rotation 0,1,2,0
    for (int p = 0; p < N; p++) setPort(p, 1'b1, 32'hA0 + p, 1'b0, CTI_CLASSIC);
    @(negedge wb_clk);
    for (int k = 0; k < 4; k++) begin
      waitGrant("t2");
      checkOutput("t2_order", wbs_adr_o, 32'hA0 + order[k]);
      g = order[k];
      stepCycle();
      setPort(g, 1'b0, 32'hA0 + g, 1'b0, CTI_CLASSIC);
      @(negedge wb_clk);
      stepCycle();
      setPort(g, 1'b1, 32'hA0 + g, 1'b0, CTI_CLASSIC);
      @(negedge wb_clk);
    end
    stepCycle();
    doReset();

    // Port 0 four-beat burst, port 2 arrives mid-burst
    setPort(0, 1'b1, 32'hB0, 1'b0, CTI_INC);
    @(negedge wb_clk);
    waitGrant("t3");
    stepCycle();
    setPort(2, 1'b1, 32'hB2, 1'b0, CTI_CLASSIC);
    wbs_ack_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wbm_cti_i[2:0] = (b == 3) ? CTI_EOB : CTI_INC;
      @(negedge wb_clk);
      checkOutput("t3_hold", wbs_adr_o, 32'hB0);
      checkOutput("t3_ack", wbm_ack_o, 3'b001);
      stepCycle();
    end
    wbs_ack_i = 1'b0;
    wbm_cti_i[2:0] = CTI_INC;
    @(negedge wb_clk);
    checkOutput("t3_eob_idle", wbs_cyc_o, 1'b0);
    stepCycle();
    @(negedge wb_clk);
    checkOutput("t3_p2_next", wbs_adr_o, 32'hB2);
    stepCycle();
    doReset();

    // Reset on beat 2 of a burst
    setPort(0, 1'b1, 32'hC0, 1'b0, CTI_INC);
    @(negedge wb_clk);
    waitGrant("t4");
    stepCycle();
    wbs_ack_i = 1'b1;
    @(negedge wb_clk);
    stepCycle();
    wb_rst = 1'b1;
    @(negedge wb_clk);
    checkOutput("t4_beat2_ack", wbm_ack_o, 3'b001);
    stepCycle();
    wb_rst = 1'b0;
    @(negedge wb_clk);
    checkOutput("t4_rst_cyc", wbs_cyc_o, 1'b0);
    checkOutput("t4_rst_ack", wbm_ack_o, 3'b000);
    stepCycle();
    @(negedge wb_clk);
    checkOutput("t4_regrant", wbs_adr_o, 32'hC0);
    stepCycle();
    doReset();

    // Slave error on port 1 classic read
    setPort(1, 1'b1, 32'hD0, 1'b0, CTI_CLASSIC);
    @(negedge wb_clk);
    waitGrant("t5");
    stepCycle();
    wbs_err_i = 1'b1;
    @(negedge wb_clk);
    checkOutput("t5_err", wbm_err_o, 3'b010);
    checkOutput("t5_no_ack", wbm_ack_o, 3'b000);
    stepCycle();
    wbs_err_i = 1'b0;
    @(negedge wb_clk);
    checkOutput("t5_hold", wbs_cyc_o, 1'b1);
    stepCycle();
    doReset();

    // Port 1 blocked by port 0: one arbitration cycle plus ten granted cycles
    setPort(0, 1'b1, 32'hE0, 1'b0, CTI_CLASSIC);
    setPort(1, 1'b1, 32'hE1, 1'b0, CTI_CLASSIC);
    @(negedge wb_clk);
    stepCycle();
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      stepCycle();
    end
    @(negedge wb_clk);
`ifdef WB_DDR_ARB_STATS_EN
    checkOutput("t6_wait_p1", stat_wait_o[63:32], 32'd11);
    checkOutput("t6_wait_p0", stat_wait_o[31:0], 32'd1);
`else
    checkOutput("t6_stats_off", stat_wait_o, 96'h0);
`endif
    stepCycle();
    doReset();

    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      @(negedge wb_clk);
      stepCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
